// File: rtl/life_game_pkg.sv
// Shared constants, FSM state encoding and word-address packing for the life engine.
// Optional feature macro used by this slice: LIFE_WRAP_EN (toroidal world).
package life_game_pkg;
  localparam int ROWS = 48;
  localparam int COLS = 64;
  localparam int WORDS_PER_ROW = 2;
  localparam int WORD_BITS = COLS / WORDS_PER_ROW;
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, PRELOAD, LOAD, STORE, SWAP} state_t;

  function automatic logic [6:0] pack_addr(input logic [5:0] y, input logic half);
    return {y, half};
  endfunction
endpackage

// File: rtl/life_game_rule.sv
// Combinational B3/S23 rule over one row, given the rows above and below.
// LIFE_WRAP_EN selects horizontal wrap; otherwise columns -1 and 64 read as dead.
module life_game_rule
  import life_game_pkg::*;
(
  input  logic [COLS-1:0] prev_row,
  input  logic [COLS-1:0] cur_row,
  input  logic [COLS-1:0] next_row,
  output logic [COLS-1:0] next_gen
);
  // Bit 0 of each extended row is column -1, bit COLS+1 is column COLS.
  logic [COLS+1:0] prev_ext;
  logic [COLS+1:0] cur_ext;
  logic [COLS+1:0] next_ext;

`ifdef LIFE_WRAP_EN
  assign prev_ext = {prev_row[0], prev_row, prev_row[COLS-1]};
  assign cur_ext  = {cur_row[0],  cur_row,  cur_row[COLS-1]};
  assign next_ext = {next_row[0], next_row, next_row[COLS-1]};
`else
  assign prev_ext = {1'b0, prev_row, 1'b0};
  assign cur_ext  = {1'b0, cur_row,  1'b0};
  assign next_ext = {1'b0, next_row, 1'b0};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_cell
      logic [3:0] count;
      assign count = 4'(prev_ext[gi]) + 4'(prev_ext[gi+1]) + 4'(prev_ext[gi+2])
                   + 4'(cur_ext[gi])                       + 4'(cur_ext[gi+2])
                   + 4'(next_ext[gi]) + 4'(next_ext[gi+1]) + 4'(next_ext[gi+2]);
      assign next_gen[gi] = (count == 4'd3) || (cur_row[gi] && (count == 4'd2));
    end
  endgenerate
endmodule

// File: rtl/life_game_engine.sv
// Streams the current world through a three-row window and writes the next generation.
// LIFE_WRAP_EN defined: toroidal world; undefined: dead border.
module life_game_engine
  import life_game_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 step,
  input  logic [WORD_BITS-1:0] cell_data_in,
  output logic [6:0]           cell_address,
  output logic                 cell_write,
  output logic [WORD_BITS-1:0] cell_data_out,
  output logic                 world_clock,
  output logic                 busy,
  output logic [15:0]          generation
);
  state_t state_reg, state_next;
  logic [1:0] sub_reg, sub_next;
  logic [5:0] row_reg, row_next;
  logic [6:0] addr_next;
  logic       write_next;
  logic [COLS-1:0] prev_reg, cur_reg, next_reg, res_reg, rule_out;
  logic [WORD_BITS-1:0] rd_word;
  logic [5:0] load_row;

`ifdef LIFE_WRAP_EN
  assign rd_word = cell_data_in;
`else
  // Reads of row -1 (preload) and row ROWS (last load) still happen; their data is dropped.
  logic wrapped_read;
  assign wrapped_read = ((state_reg == PRELOAD) && !sub_reg[1]) ||
                        ((state_reg == LOAD) && (row_reg == LAST_ROW));
  assign rd_word = wrapped_read ? '0 : cell_data_in;
`endif

  life_game_rule u_rule (
    .prev_row (prev_reg),
    .cur_row  (cur_reg),
    .next_row ({rd_word, next_reg[WORD_BITS-1:0]}),
    .next_gen (rule_out)
  );

  assign busy        = (state_reg != IDLE);
  assign world_clock = (state_reg == SWAP);
  assign load_row    = (row_next == LAST_ROW) ? 6'd0 : row_next + 6'd1;

  always_comb begin
    state_next = state_reg;
    sub_next   = sub_reg;
    row_next   = row_reg;
    case (state_reg)
      IDLE: if (step) begin
        state_next = PRELOAD;
        sub_next   = 2'd0;
      end
      PRELOAD: if (sub_reg == 2'd3) begin
        state_next = LOAD;
        sub_next   = 2'd0;
        row_next   = 6'd0;
      end else begin
        sub_next = sub_reg + 2'd1;
      end
      LOAD: if (sub_reg[0]) begin
        state_next = STORE;
        sub_next   = 2'd0;
      end else begin
        sub_next = 2'd1;
      end
      STORE: if (sub_reg[0]) begin
        sub_next = 2'd0;
        if (row_reg == LAST_ROW) begin
          state_next = SWAP;
        end else begin
          state_next = LOAD;
          row_next   = row_reg + 6'd1;
        end
      end else begin
        sub_next = 2'd1;
      end
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address and strobe are registered, so they are derived from the upcoming state.
  always_comb begin
    addr_next  = '0;
    write_next = 1'b0;
    case (state_next)
      PRELOAD: begin
        case (sub_next)
          2'd0:    addr_next = pack_addr(LAST_ROW, 1'b0);
          2'd1:    addr_next = pack_addr(LAST_ROW, 1'b1);
          2'd2:    addr_next = pack_addr(6'd0, 1'b0);
          default: addr_next = pack_addr(6'd0, 1'b1);
        endcase
      end
      LOAD:  addr_next = pack_addr(load_row, sub_next[0]);
      STORE: begin
        addr_next  = pack_addr(row_next, sub_next[0]);
        write_next = 1'b1;
      end
      default: addr_next = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      sub_reg       <= '0;
      row_reg       <= '0;
      cell_address  <= '0;
      cell_write    <= 1'b0;
      cell_data_out <= '0;
      generation    <= '0;
      prev_reg      <= '0;
      cur_reg       <= '0;
      next_reg      <= '0;
      res_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      sub_reg      <= sub_next;
      row_reg      <= row_next;
      cell_address <= addr_next;
      cell_write   <= write_next;
      case (state_reg)
        PRELOAD: begin
          case (sub_reg)
            2'd0:    prev_reg[WORD_BITS-1:0]    <= rd_word;
            2'd1:    prev_reg[COLS-1:WORD_BITS] <= rd_word;
            2'd2:    cur_reg[WORD_BITS-1:0]     <= rd_word;
            default: cur_reg[COLS-1:WORD_BITS]  <= rd_word;
          endcase
        end
        LOAD: begin
          if (!sub_reg[0]) begin
            next_reg[WORD_BITS-1:0] <= rd_word;
          end else begin
            // Upper word arrives this cycle; the rule sees it straight from the bus.
            next_reg[COLS-1:WORD_BITS] <= rd_word;
            res_reg       <= rule_out;
            cell_data_out <= rule_out[WORD_BITS-1:0];
          end
        end
        STORE: begin
          if (!sub_reg[0]) begin
            cell_data_out <= res_reg[COLS-1:WORD_BITS];
          end else begin
            prev_reg <= cur_reg;
            cur_reg  <= next_reg;
          end
        end
        SWAP:    generation <= generation + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/life_game_engine.md
# life_game_engine

Next-generation compute engine for the Game of Life display path. On each step request it streams the 48×64 current world out of `life_game_dev_io` through that block's cell port, applies the B3/S23 rule, and writes the next generation into the back buffer. It then pulses `world_clock` so the display swaps buffers. It sits directly upstream of `life_game_dev_io` and replaces CPU-driven cell writes.

## Interface
- `ROWS`, 48: world height; row `y` occupies words `{y[5:0], half}`.
- `COLS`, 64: world width; fixed at 2 × 32-bit words per row.
- `clock` in 1: sole clock; also drives `life_game_dev_io.clock`.
- `reset_n` in 1: reset, synchronous, active-low.
- `step` in 1: request one generation; sampled only in IDLE.
- `cell_data_in` in 32: current-world read data (dev_io `cell_data_out`, combinational from address).
- `cell_address` out 7: registered word address, shared by reads and writes.
- `cell_write` out 1: registered write strobe.
- `cell_data_out` out 32: registered next-generation word.
- `world_clock` out 1: one-cycle high pulse per completed generation.
- `busy` out 1: high while a generation is in progress.
- `generation` out 16: completed-generation count, wraps at 2^16.

## Operation
- States: IDLE → PRELOAD (4 cycles) → {LOAD (2), STORE (2)} × ROWS → SWAP (1) → IDLE.
- Row buffers `prev`, `cur`, `next`, each 64 bits. Cell `x` of a row is word `x[5]`, bit `x[4:0]`.
- PRELOAD reads addresses (ROWS-1,0), (ROWS-1,1), (0,0), (0,1) into `prev` and `cur`.
- Row `y` LOAD: reads row `(y+1) mod ROWS` words 0 and 1 into `next`.
- Row `y` STORE: drives `cell_write=1`, address `(y,half)`, data = selected half of rule(prev,cur,next). After the second word, `prev<=cur` and `cur<=next`.
- Rule per cell: count the 8 neighbours (0..8, 4-bit). Next state is alive if count==3, or if alive and count==2.
- SWAP: `world_clock=1`, `generation<=generation+1`.
- Reads always target the displayed buffer and writes the back buffer, so there is no read/write hazard. All 96 words are rewritten every generation.
- `step` in any non-IDLE state, including SWAP, is ignored and not queued.
- Reset during operation returns the block to IDLE next edge with no `world_clock` pulse. The partial back buffer is harmless because the next generation fully overwrites it.

## Timing
- Reset values: `cell_address=0`, `cell_write=0`, `cell_data_out=0`, `world_clock=0`, `busy=0`, `generation=0`.
- `step` is sampled at edge E0. `busy` is high for cycles 1..197 after E0.
- Cycles 1-4 PRELOAD, 5-196 row loop, 197 SWAP.
- Data is sampled at the end of the cycle in which `cell_address` is valid.
- First write is cycle 7, address 0. The last write is cycle 196, address 95.
- `world_clock` is high in cycle 197 only. The earliest next `step` is accepted at edge 198.
- Cycle count is fixed; it is independent of world contents and of the configuration below.

## Configuration
- `LIFE_WRAP_EN` defined: toroidal world. Row `-1` maps to ROWS-1 and row ROWS to 0; column `-1` maps to 63 and column 64 to 0.
- Undefined: dead border. Out-of-range rows and columns read as 0. Wrapped reads are still issued to keep timing fixed, but their data is replaced by zero.

## Structure
- `life_game_pkg`: ROWS, COLS, WORDS_PER_ROW, state enum, address-pack function `{y, half}`.
- Sub-module `life_game_rule`: purely combinational. Takes three 64-bit rows and yields a 64-bit next row. Horizontal wrap is selected by `LIFE_WRAP_EN`.

## Test plan
- Reset: hold `reset_n=0` 3 cycles → all outputs 0, state IDLE.
- Glider: memory words 0=0x2, 2=0x4, 4=0x7, one `step` → written words 2=0x5, 4=0x6, 6=0x2, all others 0. `world_clock` pulses at cycle 197; `generation=1`.
- Wrap blinker: words 0=0x3, 1=0x80000000. With `LIFE_WRAP_EN` → words 94, 0, 2 each 0x1, rest 0. Without it → all 96 words 0.
- Address sequence: cycles 1-6 addresses 94, 95, 0, 1, 2, 3 with `cell_write=0`. Cycles 7-8 addresses 0, 1 with `cell_write=1`.
- Step while busy: extra `step` pulses at cycles 50 and 197 → exactly one `world_clock` pulse, `generation=1`.
- Reset mid-op: `reset_n=0` at cycle 100 → next cycle `busy=0`, `cell_write=0`, no `world_clock` pulse, `generation=0`.
